// File: rtl/msg_filter_pkg.sv
// msg_filter_pkg -- shared types and constants for the msg_filter block.
//   state_e   : packet-tracking FSM state (IDLE between packets, PASS, DROP)
//   CNT_W_DEF : default statistics counter width
package msg_filter_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

endpackage

// File: rtl/msg_filter_if.sv
// avalon_st_if -- Avalon-ST style packet stream (valid/ready handshake).
//   valid, data, empty, sop, eop : source -> sink
//   ready                        : sink -> source
// Modports: master (source side), slave (sink side).
interface avalon_st_if #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3
) ();

  logic               valid;
  logic               ready;
  logic [DATA_W-1:0]  data;
  logic [EMPTY_W-1:0] empty;
  logic               sop;
  logic               eop;

  modport master (output valid, data, empty, sop, eop, input ready);
  modport slave  (input valid, data, empty, sop, eop, output ready);

endinterface

// File: rtl/msg_filter_sat_cnt.sv
// msg_filter_sat_cnt -- saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one (ignored once the counter is all ones)
//   clr        : synchronous clear, wins over inc
//   cnt        : current count
module msg_filter_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/msg_filter.sv
// msg_filter -- drops or passes whole packets of an Avalon-ST stream.
// A drop request sampled on each accepted sop decides the fate of that
// packet. Beats arriving outside a packet (orphans) are discarded.
// Forwarded beats are registered (1 cycle latency); discarded beats never
// stall the input.
//   clk, rst_n      : clock, asynchronous active-low reset
//   drop            : drop request, sampled on an accepted sop beat only
//   msg_in          : input stream (slave)
//   msg_out         : filtered output stream (master)
//   drop_indication : high while dropping (incl. the deciding sop cycle)
//   stats_clr       : synchronous clear of all statistics counters
//   pass_cnt, drop_cnt, orphan_cnt, restart_cnt : saturating statistics
// Build option: define MSG_FILTER_STATS_EN to build the statistics
// counters; otherwise the counter ports read 0 and stats_clr is ignored.
module msg_filter
  import msg_filter_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             drop,
  avalon_st_if.slave       msg_in,
  avalon_st_if.master      msg_out,
  output logic             drop_indication,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] orphan_cnt,
  output logic [CNT_W-1:0] restart_cnt
);

  state_e             state_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [EMPTY_W-1:0] out_empty_q;
  logic               out_sop_q;
  logic               out_eop_q;

  logic acc;   // beat accepted this cycle
  logic disc;  // beat is being discarded
  logic fwd;   // beat is accepted and forwarded

  // A sop decides its own fate from drop; any other beat follows the
  // current packet, and outside a packet (IDLE) it is an orphan.
  assign disc = msg_in.valid & (msg_in.sop ? drop : (state_q != ST_PASS));
  // Discarded beats never touch the output register, so they never stall.
  assign msg_in.ready = ~out_valid_q | msg_out.ready | disc;
  assign acc = msg_in.valid & msg_in.ready;
  assign fwd = acc & ~disc;

  assign drop_indication = (state_q == ST_DROP) | (acc & msg_in.sop & drop);

  assign msg_out.valid = out_valid_q;
  assign msg_out.data  = out_data_q;
  assign msg_out.empty = out_empty_q;
  assign msg_out.sop   = out_sop_q;
  assign msg_out.eop   = out_eop_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_empty_q <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      if (acc) begin
        if (msg_in.sop) begin
          // A new sop restarts the decision even mid-packet; a single-beat
          // packet leaves us back in IDLE.
          if (msg_in.eop) state_q <= ST_IDLE;
          else            state_q <= drop ? ST_DROP : ST_PASS;
        end else if (msg_in.eop) begin
          state_q <= ST_IDLE;
        end
      end

      // fwd implies the register was empty or being drained this cycle.
      if (fwd) begin
        out_valid_q <= 1'b1;
        out_data_q  <= msg_in.data;
        out_empty_q <= msg_in.empty;
        out_sop_q   <= msg_in.sop;
        out_eop_q   <= msg_in.eop;
      end else if (msg_out.ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef MSG_FILTER_STATS_EN
  logic pass_inc, drop_inc, orphan_inc, restart_inc;

  assign pass_inc    = fwd & msg_in.eop;
  // Only eops of packets dropped on request count; orphan eops do not.
  assign drop_inc    = acc & msg_in.eop &
                       (msg_in.sop ? drop : (state_q == ST_DROP));
  assign orphan_inc  = acc & ~msg_in.sop & (state_q == ST_IDLE);
  assign restart_inc = acc & msg_in.sop & (state_q != ST_IDLE);

  msg_filter_sat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk(clk), .rst_n(rst_n), .inc(pass_inc), .clr(stats_clr), .cnt(pass_cnt)
  );
  msg_filter_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .inc(drop_inc), .clr(stats_clr), .cnt(drop_cnt)
  );
  msg_filter_sat_cnt #(.CNT_W(CNT_W)) u_orphan_cnt (
    .clk(clk), .rst_n(rst_n), .inc(orphan_inc), .clr(stats_clr), .cnt(orphan_cnt)
  );
  msg_filter_sat_cnt #(.CNT_W(CNT_W)) u_restart_cnt (
    .clk(clk), .rst_n(rst_n), .inc(restart_inc), .clr(stats_clr), .cnt(restart_cnt)
  );
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;

  assign pass_cnt    = '0;
  assign drop_cnt    = '0;
  assign orphan_cnt  = '0;
  assign restart_cnt = '0;
`endif

endmodule

// File: tb/tb_msg_filter.sv
// tb_msg_filter -- scoreboard bench for msg_filter. The driver pushes each
// forwarded beat (with its acceptance cycle) into a queue; an independent
// monitor pops and compares on every output handshake. A second instance
// with CNT_W=4 exercises counter saturation and clear priority.
module tb_msg_filter;
  import msg_filter_pkg::*;

  localparam int DW = 64;
  localparam int EW = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
    int            t_acc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drop = 1'b0;
  logic stats_clr = 1'b0;
  logic drop_indication;
  logic [31:0] pass_cnt, drop_cnt, orphan_cnt, restart_cnt;

  avalon_st_if #(.DATA_W(DW), .EMPTY_W(EW)) in_if ();
  avalon_st_if #(.DATA_W(DW), .EMPTY_W(EW)) out_if ();

  msg_filter #(.DATA_W(DW), .EMPTY_W(EW), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .drop(drop), .msg_in(in_if), .msg_out(out_if),
    .drop_indication(drop_indication), .stats_clr(stats_clr),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt),
    .orphan_cnt(orphan_cnt), .restart_cnt(restart_cnt)
  );

  // Narrow-counter instance.
  logic drop4 = 1'b0;
  logic stats_clr4 = 1'b0;
  logic drop_ind4;
  logic [3:0] pass4, drop4_cnt, orphan4, restart4;
  avalon_st_if #(.DATA_W(DW), .EMPTY_W(EW)) in4 ();
  avalon_st_if #(.DATA_W(DW), .EMPTY_W(EW)) out4 ();

  msg_filter #(.DATA_W(DW), .EMPTY_W(EW), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .drop(drop4), .msg_in(in4), .msg_out(out4),
    .drop_indication(drop_ind4), .stats_clr(stats_clr4),
    .pass_cnt(pass4), .drop_cnt(drop4_cnt),
    .orphan_cnt(orphan4), .restart_cnt(restart4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int di_cnt = 0;
  bit rand_bp = 1'b0;
  beat_t exp_q[$];

  // Reference model state and counters.
  state_e m_state = ST_IDLE;
  int m_pass = 0, m_drop = 0, m_orphan = 0, m_restart = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Counters read 0 when the statistics option is not built.
  function automatic logic [31:0] ex(input int v);
`ifdef MSG_FILTER_STATS_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (drop_indication) di_cnt++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) out_if.ready = 1'($urandom_range(0, 1));
  end

  // Monitor: latency on first presentation, content on handshake.
  initial begin
    bit head_new;
    beat_t b;
    head_new = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        head_new = 1'b1;
      end else begin
        if (out_if.valid && head_new) begin
          head_new = 1'b0;
          if (exp_q.size() == 0) check("unexpected_out", 1, 0);
          else                   check("latency", cyc, exp_q[0].t_acc);
        end
        if (out_if.valid && out_if.ready) begin
          head_new = 1'b1;
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("beat", {out_if.data, out_if.empty, out_if.sop, out_if.eop},
                  {b.data, b.empty, b.sop, b.eop});
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [DW-1:0] data, input logic [EW-1:0] empty,
                      input logic sop, input logic eop, input logic dr,
                      input bit chk_ready);
    bit fwd;
    bit got;
    beat_t b;
    in_if.valid = 1'b1;
    in_if.data  = data;
    in_if.empty = empty;
    in_if.sop   = sop;
    in_if.eop   = eop;
    drop        = dr;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (chk_ready && n == 0) check("in_ready", in_if.ready, 1);
      if (in_if.ready) begin
        got = 1'b1;
        fwd = sop ? !dr : (m_state == ST_PASS);
        if (fwd) begin
          b.data = data; b.empty = empty; b.sop = sop; b.eop = eop;
          b.t_acc = cyc + 1;
          exp_q.push_back(b);
        end
        if (sop && m_state != ST_IDLE) m_restart++;
        if (!sop && m_state == ST_IDLE) m_orphan++;
        if (eop) begin
          if (fwd) m_pass++;
          else if (sop ? dr : (m_state == ST_DROP)) m_drop++;
        end
        if (sop) m_state = eop ? ST_IDLE : (dr ? ST_DROP : ST_PASS);
        else if (eop) m_state = ST_IDLE;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_if.valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    m_pass = 0; m_drop = 0; m_orphan = 0; m_restart = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_pass"},    pass_cnt,    ex(m_pass));
    check({tag, "_drop"},    drop_cnt,    ex(m_drop));
    check({tag, "_orphan"},  orphan_cnt,  ex(m_orphan));
    check({tag, "_restart"}, restart_cnt, ex(m_restart));
  endtask

  initial begin
    int plen;
    logic pdr, s, e;
    in_if.valid = 1'b0; in_if.data = '0; in_if.empty = '0;
    in_if.sop = 1'b0; in_if.eop = 1'b0;
    out_if.ready = 1'b1;
    in4.valid = 1'b0; in4.data = '0; in4.empty = '0; in4.sop = 1'b0; in4.eop = 1'b0;
    out4.ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_fields", {out_if.data, out_if.empty, out_if.sop, out_if.eop}, 0);
    check("rst_drop_ind", drop_indication, 0);
    check("rst_pass4", pass4, 0);
    check_cnts("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3-beat packet passed at full rate
    clear_stats();
    send(64'h1111_0000_0000_0001, 3'd0, 1, 0, 0, 1);
    send(64'h2222_0000_0000_0002, 3'd0, 0, 0, 1, 1);
    send(64'h3333_0000_0000_0003, 3'd5, 0, 1, 0, 1);
    idle(2);
    drain();
    check_cnts("pass3");

    // 3-beat packet dropped under full backpressure
    clear_stats();
    out_if.ready = 1'b0;
    di_cnt = 0;
    send(64'hD0D0_0000_0000_0001, 3'd0, 1, 0, 1, 1);
    send(64'hD0D0_0000_0000_0002, 3'd0, 0, 0, 0, 1);
    send(64'hD0D0_0000_0000_0003, 3'd2, 0, 1, 0, 1);
    idle(3);
    check("drop_no_output", out_if.valid, 0);
    check("drop_ind_cycles", di_cnt, 3);
    check_cnts("drop3");
    out_if.ready = 1'b1;

    // Orphan beat in IDLE
    clear_stats();
    send(64'hAA, 3'd0, 0, 0, 0, 1);
    idle(2);
    check("orphan_drop_ind", drop_indication, 0);
    check_cnts("orphan");

    // Truncated packet A followed by packet B
    clear_stats();
    send(64'hA000_0000_0000_0001, 3'd0, 1, 0, 0, 1);
    send(64'hA000_0000_0000_0002, 3'd0, 0, 0, 0, 1);
    send(64'hB000_0000_0000_0001, 3'd0, 1, 0, 0, 1);
    send(64'hB000_0000_0000_0002, 3'd0, 0, 0, 0, 1);
    send(64'hB000_0000_0000_0003, 3'd7, 0, 1, 0, 1);
    idle(2);
    drain();
    check_cnts("restart");

    // Reset mid-packet: the rest of the packet becomes orphans
    send(64'hC000_0000_0000_0001, 3'd0, 1, 0, 0, 1);
    idle(2);
    drain();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_state = ST_IDLE;
    m_pass = 0; m_drop = 0; m_orphan = 0; m_restart = 0;
    send(64'hC000_0000_0000_0002, 3'd0, 0, 0, 0, 1);
    send(64'hE000_0000_0000_0001, 3'd1, 1, 1, 0, 1);
    idle(2);
    drain();
    check_cnts("midrst");

    // Random backpressure, 100 packets, ~50% dropped
    clear_stats();
    rand_bp = 1'b1;
    for (int p = 0; p < 100; p++) begin
      plen = $urandom_range(1, 4);
      pdr  = 1'($urandom_range(0, 1));
      for (int i = 0; i < plen; i++) begin
        s = (i == 0);
        e = (i == plen - 1);
        send({$urandom, $urandom}, e ? 3'($urandom_range(0, 7)) : 3'd0, s, e,
             s ? pdr : 1'($urandom_range(0, 1)), 0);
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
    rand_bp = 1'b0;
    out_if.ready = 1'b1;
    idle(1);
    drain();
    check("rand_total", pass_cnt + drop_cnt, ex(100));
    check_cnts("rand");

    // Narrow counters: saturation, then clear beats a concurrent eop
    in4.valid = 1'b1; in4.sop = 1'b1; in4.eop = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    in4.valid = 1'b0;
    @(posedge clk);
    #1;
    check("sat_pass4", pass4, 4'(ex(15)));
    in4.valid = 1'b1;
    stats_clr4 = 1'b1;
    @(posedge clk);
    #1;
    in4.valid = 1'b0;
    stats_clr4 = 1'b0;
    check("clr_pass4", pass4, 0);
    in4.valid = 1'b1;
    @(posedge clk);
    #1;
    in4.valid = 1'b0;
    check("after_clr_pass4", pass4, 4'(ex(1)));

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
